pll_phase_stepper: RTL
======================

// Module: pll_phase_stepper
// PURPOSE
//  Drives the dynamic phase-shift port of an ECP5 EHXPLLL (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG),
//  i.e. the controlling side of the interface our fixed-phase PLL wrappers tie off.
//  Accepts "shift output X by N steps, direction D" requests, emits correctly timed PHASESTEP pulses,
//  waits for re-lock and tracks the net step position per output. Clocked from a PLL-independent clock.
// PARAMETERS
//  STEP_W       8    width of req_steps (max steps per request = 2**STEP_W-1)
//  POS_W        8    width of each signed net-position counter (wraps modulo 2**POS_W)
//  SETUP_CYC    2    cycles phasesel/phasedir are held stable before a pulse (>=1)
//  PULSE_CYC    4    cycles phasestep is held low per step (>=1)
//  GAP_CYC      4    cycles phasestep is held high between steps (>=1)
//  LOCK_TIMEOUT 1024 max cycles to wait for pll_locked after the last step
// PORTS
//  clock        in   1          system clock (must not be derived from the PLL being shifted)
//  resetn       in   1          asynchronous, active-low reset
//  req_valid    in   1          request valid
//  req_ready    out  1          high only in IDLE; transfer when req_valid & req_ready
//  req_sel      in   2          00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP (EHXPLLL encoding)
//  req_dir      in   1          0 = delay (lag), 1 = advance (lead)
//  req_steps    in   STEP_W     number of steps; 0 is legal
//  pll_locked   in   1          PLL LOCK, asynchronous; double-flop synchronised inside
//  phasesel     out  2          to PLL PHASESEL[1:0]
//  phasedir     out  1          to PLL PHASEDIR
//  phasestep    out  1          to PLL PHASESTEP; idle high, active-low pulse
//  phaseloadreg out  1          to PLL PHASELOADREG; constant 1
//  busy         out  1          ~req_ready
//  done         out  1          1-cycle pulse on request completion (also on timeout)
//  timeout_err  out  1          sticky: last request timed out waiting for lock
//  phase_pos    out  4*POS_W    net signed steps per output; slice i = phasesel value i
// BEHAVIOUR
//  Reset (async): state IDLE, req_ready=1, phasesel=00, phasedir=1, phasestep=1, phaseloadreg=1,
//   done=0, timeout_err=0, phase_pos=0, lock synchroniser=0. Reset mid-pulse returns phasestep high at once.
//  All outputs registered. FSM: IDLE -> SETUP -> PULSE -> GAP -> (PULSE | LOCKWAIT) -> IDLE.
//  IDLE: on handshake latch sel/dir/steps into phasesel/phasedir/remaining; clear timeout_err.
//   steps==0: go straight to LOCKWAIT (no pulse, no phase_pos change).
//  SETUP: hold SETUP_CYC cycles, phasestep high.
//  PULSE: phasestep low for exactly PULSE_CYC cycles; on exit remaining-=1, phase_pos[sel] += dir?+1:-1.
//  GAP: phasestep high GAP_CYC cycles; remaining!=0 -> PULSE, else LOCKWAIT.
//  LOCKWAIT: counter from 0; synced lock high -> IDLE with done=1 next cycle;
//   count reaches LOCK_TIMEOUT-1 -> IDLE with done=1, timeout_err=1.
//  phasesel/phasedir change only in IDLE on handshake; stable through the whole request.
//  Lock loss during SETUP/PULSE/GAP is ignored; only LOCKWAIT samples lock.
//  phase_pos wraps two's complement modulo 2**POS_W; no saturation.
//  req_valid while busy: ignored (req_ready=0); requester must hold valid.
//  Latency, N>0 steps, lock already high: SETUP_CYC + N*(PULSE_CYC+GAP_CYC) + 1 cycles to done.
// STRUCTURE
//  Package pll_phase_pkg: PHASESEL_* encodings, DIR_DELAY/DIR_ADVANCE, FSM state enum.
//  Sub-module: sync2 (2-flop synchroniser, async active-low reset) for pll_locked.
//  Remainder flat: FSM, one shared cycle counter (setup/pulse/gap/lockwait), step counter, 4 pos regs.
// TESTING
//  1 Reset: resetn=0 mid-PULSE -> phasestep=1, req_ready=1, phase_pos=0 same cycle, no done.
//  2 Defaults, lock=1, req sel=10 dir=1 steps=3 -> three low pulses of 4 cycles, 4-cycle gaps;
//    phasesel=10 throughout; done 27 cycles after handshake; phase_pos[2]=+3.
//  3 steps=0, lock=1 -> no phasestep activity; done within 3 cycles; phase_pos unchanged.
//  4 lock held 0 -> done 1024 cycles into LOCKWAIT, timeout_err=1; next accepted request clears it.
//  5 POS_W=8: 200 delay steps on CLKOP (sel=11) from 0 -> phase_pos[3]=8'h38 (-200 mod 256).
//  6 req_valid held during busy -> exactly one handshake per request; phasesel/dir never change mid-request.

Source files
------------

// File: rtl/pll_phase_pkg.sv
// Shared encodings for the ECP5 EHXPLLL dynamic phase-shift controller.
// Covers PHASESEL output select, PHASEDIR direction and the stepper FSM states.
package pll_phase_pkg;

    localparam logic [1:0] PHASESEL_CLKOS  = 2'b00;
    localparam logic [1:0] PHASESEL_CLKOS2 = 2'b01;
    localparam logic [1:0] PHASESEL_CLKOS3 = 2'b10;
    localparam logic [1:0] PHASESEL_CLKOP  = 2'b11;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_LOCKWAIT
    } state_t;

endpackage

// File: rtl/pll_phase_stepper_sync2.sv
// Two-flop synchroniser for the asynchronous PLL lock flag.
// Both flops clear on reset, so the stepper treats the PLL as unlocked until it proves otherwise.
module pll_phase_stepper_sync2 (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_stepper.sv
// Controller for the EHXPLLL dynamic phase-shift port: turns step requests into timed
// active-low PHASESTEP pulses, waits for re-lock and keeps a net step position per output.
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int STEP_W       = 8,
    parameter int POS_W        = 8,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic               req_dir,
    input  logic [STEP_W-1:0]  req_steps,
    input  logic               pll_locked,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic               phaseloadreg,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [4*POS_W-1:0] phase_pos
);

    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (GAP_CYC > LOCK_TIMEOUT) ? GAP_CYC : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    lock_sync;
    logic                    handshake;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [STEP_W-1:0]       remaining;
    logic [STEP_W-1:0]       remaining_next;
    logic [3:0][POS_W-1:0]   pos;
    logic [3:0][POS_W-1:0]   pos_next;
    logic [POS_W-1:0]        delta;
    logic [1:0]              phasesel_next;
    logic                    phasedir_next;
    logic                    phasestep_next;
    logic                    req_ready_next;
    logic                    done_next;
    logic                    timeout_next;

    pll_phase_stepper_sync2 u_lock_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_sync)
    );

    assign handshake    = req_valid & req_ready;
    assign phaseloadreg = 1'b1;
    assign phase_pos    = pos;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // One shared counter times every phase; it restarts whenever the state changes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = (req_steps == '0) ? ST_LOCKWAIT : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = (remaining != '0) ? ST_PULSE : ST_LOCKWAIT;
                end
            end
            ST_LOCKWAIT: begin
                if (lock_sync || (cnt == LOCK_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_next       = (state_next == state && state_next != ST_IDLE) ? cnt + CNT_W'(1) : '0;
        phasesel_next  = phasesel;
        phasedir_next  = phasedir;
        remaining_next = remaining;
        pos_next       = pos;
        timeout_next   = timeout_err;
        delta          = (phasedir == DIR_DELAY) ? '1 : POS_W'(1);

        if (handshake) begin
            phasesel_next  = req_sel;
            phasedir_next  = req_dir;
            remaining_next = req_steps;
            timeout_next   = 1'b0;
        end

        // A step is counted as taken once its low pulse has fully completed.
        if (state == ST_PULSE && state_next == ST_GAP) begin
            remaining_next = remaining - STEP_W'(1);
            case (phasesel)
                PHASESEL_CLKOS:  pos_next[0] = pos[0] + delta;
                PHASESEL_CLKOS2: pos_next[1] = pos[1] + delta;
                PHASESEL_CLKOS3: pos_next[2] = pos[2] + delta;
                PHASESEL_CLKOP:  pos_next[3] = pos[3] + delta;
                default:         pos_next    = pos;
            endcase
        end

        if (state == ST_LOCKWAIT && state_next == ST_IDLE && !lock_sync) begin
            timeout_next = 1'b1;
        end

        phasestep_next = (state_next != ST_PULSE);
        req_ready_next = (state_next == ST_IDLE);
        done_next      = (state == ST_LOCKWAIT) && (state_next == ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            remaining   <= '0;
            pos         <= '0;
            phasesel    <= PHASESEL_CLKOS;
            phasedir    <= DIR_ADVANCE;
            phasestep   <= 1'b1;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            remaining   <= remaining_next;
            pos         <= pos_next;
            phasesel    <= phasesel_next;
            phasedir    <= phasedir_next;
            phasestep   <= phasestep_next;
            req_ready   <= req_ready_next;
            busy        <= ~req_ready_next;
            done        <= done_next;
            timeout_err <= timeout_next;
        end
    end

endmodule
